// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width functions,
// wrap-increment and handshake op encoding.
package sync_fifo_pkg;

  typedef int unsigned uint_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int lvl_width(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Wraps at depth-1, so non-power-of-two depths work.
  function automatic uint_t ptr_inc(uint_t ptr, uint_t depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrap-around pointer for the FIFO: enable to advance,
// clr to return to 0 synchronously.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (en_i) begin
      ptr_o <= PW'(ptr_inc(uint_t'(ptr_o), uint_t'(DEPTH)));
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with level and almost flags.
// SYNC_FIFO_FALL_THROUGH_EN enables the empty-FIFO bypass.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BUFFER_DEPTH    = 8,
  parameter int ALMOST_FULL_TH  = BUFFER_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [lvl_width(BUFFER_DEPTH)-1:0] level_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o
);

  localparam int LW = lvl_width(BUFFER_DEPTH);
  localparam int PW = ptr_width(BUFFER_DEPTH);

  localparam logic [LW-1:0] FULL  = LW'(BUFFER_DEPTH);
  localparam logic [LW-1:0] AF_TH = LW'(ALMOST_FULL_TH);
  localparam logic [LW-1:0] AE_TH = LW'(ALMOST_EMPTY_TH);

  if (BUFFER_DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo: BUFFER_DEPTH must be >= 2");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > BUFFER_DEPTH) begin : g_chk_af
    $error("sync_fifo: ALMOST_FULL_TH out of range");
  end
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > BUFFER_DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo: ALMOST_EMPTY_TH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [LW-1:0]         level_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  empty;
  logic                  bypass;
  logic                  push_ok;
  logic                  pop_ok;
  op_e                   op;

  assign empty = (level_q == '0);

`ifdef SYNC_FIFO_FALL_THROUGH_EN
  assign bypass = empty & valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed beat that is consumed never touches storage.
  assign push_ok = valid_i & ready_o & ~flush_i & ~(bypass & ready_i);
  assign pop_ok  = ~empty & ready_i & ~flush_i;
  assign op      = op_e'({push_ok, pop_ok});

  sync_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PW    (PW)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .en_i  (push_ok),
    .ptr_o (wr_ptr)
  );

  sync_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PW    (PW)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .en_i  (pop_ok),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        if (push_ok && wr_ptr == PW'(i)) begin
          mem[i] <= data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else if (flush_i) begin
      level_q <= '0;
    end else begin
      unique case (op)
        OP_PUSH: level_q <= level_q + LW'(1);
        OP_POP:  level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    data_o = mem[rd_ptr];
    if (bypass) begin
      data_o = data_i;
    end
  end

  assign valid_o        = ~empty | bypass;
  assign ready_o        = (level_q != FULL);
  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= AF_TH);
  assign almost_empty_o = (level_q <= AE_TH);

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a
// queue-based reference model (depth 5).
module tb_sync_fifo;

  localparam int DW  = 32;
  localparam int DEP = 5;
  localparam int AF  = 4;
  localparam int AE  = 1;
  localparam int LW  = $clog2(DEP + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [LW-1:0] level_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] q[$];

  sync_fifo #(
    .DATA_WIDTH      (DW),
    .BUFFER_DEPTH    (DEP),
    .ALMOST_FULL_TH  (AF),
    .ALMOST_EMPTY_TH (AE)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of stimulus: drive after negedge, compare, then
  // advance the model to what the next edge must produce.
  task automatic cyc(input logic v, input logic r, input logic f,
                     input logic [DW-1:0] d);
    int  lvl;
    bit  byp;
    bit  ev;
    @(negedge clk_i);
    valid_i = v;
    ready_i = r;
    flush_i = f;
    data_i  = d;
    #1;
    lvl = q.size();
`ifdef SYNC_FIFO_FALL_THROUGH_EN
    byp = (lvl == 0) && v && !f;
`else
    byp = 1'b0;
`endif
    ev = (lvl != 0) || byp;
    check("ready", 32'(ready_o), 32'(lvl != DEP));
    check("valid", 32'(valid_o), 32'(ev));
    check("level", 32'(level_o), 32'(lvl));
    check("afull", 32'(almost_full_o), 32'(lvl >= AF));
    check("aempty", 32'(almost_empty_o), 32'(lvl <= AE));
    if (lvl != 0) check("data", data_o, q[0]);
    else if (byp) check("data_byp", data_o, d);
    if (f) begin
      q.delete();
    end else if (!(byp && r)) begin
      if (r && lvl > 0) void'(q.pop_front());
      if (v && lvl < DEP) q.push_back(d);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_ord[5];
    exp_ord[0] = 32'h33;
    exp_ord[1] = 32'h44;
    exp_ord[2] = 32'h55;
    exp_ord[3] = 32'h66;
    exp_ord[4] = 32'h77;

    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_aempty", 32'(almost_empty_o), 32'd1);
    check("rst_afull", 32'(almost_full_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // latency: push into empty FIFO
    cyc(1'b1, 1'b0, 1'b0, 32'hA5);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("lat_data", data_o, 32'hA5);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // non-power-of-two fill and wrap
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, DW'(i * 'h11));
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_full_rdy", 32'(ready_o), 32'd0);
    check("wrap_full_af", 32'(almost_full_o), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h66);
    cyc(1'b1, 1'b0, 1'b0, 32'h77);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check("wrap_order", data_o, exp_ord[i]);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // simultaneous push/pop at level 2
    cyc(1'b1, 1'b0, 1'b0, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h101);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, DW'(32'h200 + i));
      check("stream_lvl", 32'(level_o), 32'd2);
    end

    // flush priority at level 3
    cyc(1'b1, 1'b0, 1'b0, 32'h300);
    cyc(1'b1, 1'b1, 1'b1, 32'hDEAD);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("flush_lvl", 32'(level_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);

    // backpressure while full
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, DW'(32'h400 + i));
    cyc(1'b1, 1'b1, 1'b0, 32'h4FF);
    cyc(1'b1, 1'b0, 1'b0, 32'h4FF);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("bp_level", 32'(level_o), 32'd5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 24) == 0), $urandom);
    end

    // asynchronous reset with 3 entries stored
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, DW'(32'h500 + i));
    @(negedge clk_i);
    valid_i = 1'b1;
    ready_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_level", 32'(level_o), 32'd0);
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_aempty", 32'(almost_empty_o), 32'd1);
    check("arst_afull", 32'(almost_full_o), 32'd0);
    q.delete();
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_i   = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h600);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
